// File: rtl/conv_accum_pkg.sv
// Shared constants, saturation helpers and accumulator FSM encoding for
// the 27x16 convolution accumulator.
package conv_accum_pkg;

  localparam int BITSIZE   = 14;
  localparam int FRAC_BITS = 7;
  localparam int ACC_W     = 32;
  localparam int GRP_W     = 8;
  localparam int NUM_TAPS  = 27;
  localparam int NUM_FILT  = 16;
  localparam int PROD_W    = 2*BITSIZE - FRAC_BITS;
  localparam int TREE_W    = PROD_W + 5;
  localparam int SAT_W     = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Clamp a sign-extended value into a signed w-bit range, returned sign-extended.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/conv_accum_27x16_tree.sv
// adder_tree_27: three-stage pipelined signed reducer of 27 products
// (27 -> 9 -> 3 -> 1) with a shared enable and a per-stage valid bit.
module adder_tree_27
  import conv_accum_pkg::*;
#(
  parameter int PW = PROD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic [NUM_TAPS*PW-1:0]   prod_i,
  output logic signed [PW+4:0]     sum_o,
  output logic                     valid_o,
  output logic                     busy_o
);

  logic signed [PW-1:0] p_s  [NUM_TAPS];
  logic signed [PW+1:0] s1_d [9];
  logic signed [PW+1:0] s1_q [9];
  logic signed [PW+3:0] s2_d [3];
  logic signed [PW+3:0] s2_q [3];
  logic signed [PW+4:0] s3_d;
  logic signed [PW+4:0] s3_q;
  logic [2:0]           v_q;

  // Combinational sums of three for every stage; widths grow to stay exact.
  always_comb begin
    for (int j = 0; j < NUM_TAPS; j++) begin
      p_s[j] = prod_i[j*PW +: PW];
    end
    for (int k = 0; k < 9; k++) begin
      s1_d[k] = (PW+2)'(p_s[3*k]) + (PW+2)'(p_s[3*k+1]) + (PW+2)'(p_s[3*k+2]);
    end
    for (int k = 0; k < 3; k++) begin
      s2_d[k] = (PW+4)'(s1_q[3*k]) + (PW+4)'(s1_q[3*k+1]) + (PW+4)'(s1_q[3*k+2]);
    end
    s3_d = (PW+5)'(s2_q[0]) + (PW+5)'(s2_q[1]) + (PW+5)'(s2_q[2]);
  end

  // Pipeline registers; all stages hold together when en_i is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) s1_q[k] <= '0;
      for (int k = 0; k < 3; k++) s2_q[k] <= '0;
      s3_q <= '0;
      v_q  <= 3'b000;
    end else if (en_i) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      v_q  <= {v_q[1:0], valid_i};
    end
  end

  assign sum_o   = s3_q;
  assign valid_o = v_q[2];
  assign busy_o  = |v_q;

endmodule

// File: rtl/conv_accum_27x16.sv
// Reduces 16 filters x 27 products per beat, accumulates over num_groups
// beats and emits 16 saturated results. Define CONV_ACCUM_RELU_EN to clamp negatives to 0.
module conv_accum_27x16
  import conv_accum_pkg::*;
#(
  parameter int bitsize   = BITSIZE,
  parameter int FRAC_BITS = conv_accum_pkg::FRAC_BITS,
  parameter int ACC_W     = conv_accum_pkg::ACC_W,
  parameter int GRP_W     = conv_accum_pkg::GRP_W
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [(2*bitsize-FRAC_BITS)*NUM_TAPS*NUM_FILT-1:0] Mult_result,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [GRP_W-1:0]                                   num_groups,
  output logic [bitsize*NUM_FILT-1:0]                        out_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [NUM_FILT-1:0]                                sat_flag,
  output logic                                               busy
);

  localparam int PW = 2*bitsize - FRAC_BITS;
  localparam int TW = PW + 5;
  localparam logic [GRP_W-1:0] GRP_ONE = {{(GRP_W-1){1'b0}}, 1'b1};

  logic signed [TW-1:0]    tree_sum [NUM_FILT];
  logic [NUM_FILT-1:0]     tree_v;
  logic [NUM_FILT-1:0]     tree_busy;
  logic                    en_s;
  logic                    s3_v;

  acc_state_e              state_q, state_d;
  logic [GRP_W-1:0]        grp_cnt_q, grp_cnt_d;
  logic [GRP_W-1:0]        grp_max_q, grp_max_d;
  logic signed [ACC_W-1:0] acc_q [NUM_FILT];
  logic signed [ACC_W-1:0] acc_d [NUM_FILT];
  logic [NUM_FILT-1:0]     acc_sat_q, acc_sat_d;
  logic [bitsize*NUM_FILT-1:0] out_data_q, out_data_d;
  logic [NUM_FILT-1:0]     sat_flag_q, sat_flag_d;
  logic                    out_valid_q, out_valid_d;

  logic                    first_s;
  logic                    last_s;
  logic [GRP_W-1:0]        gmax_s;
  logic signed [ACC_W-1:0] base_s;
  logic signed [SAT_W-1:0] wide_s;
  logic signed [SAT_W-1:0] acc_s;
  logic signed [SAT_W-1:0] res_s;

  assign en_s = !(out_valid_q && !out_ready);

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_tree
    adder_tree_27 #(.PW(PW)) u_tree (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_s),
      .valid_i (in_valid),
      .prod_i  (Mult_result[f*NUM_TAPS*PW +: NUM_TAPS*PW]),
      .sum_o   (tree_sum[f]),
      .valid_o (tree_v[f]),
      .busy_o  (tree_busy[f])
    );
  end

  // All trees advance in lockstep, so their valid bits are identical.
  assign s3_v = &tree_v;

  // Accumulate stage, group FSM and output load.
  always_comb begin
    state_d     = state_q;
    grp_cnt_d   = grp_cnt_q;
    grp_max_d   = grp_max_q;
    acc_d       = acc_q;
    acc_sat_d   = acc_sat_q;
    out_data_d  = out_data_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = out_valid_q && !out_ready;
    base_s      = '0;
    wide_s      = '0;
    acc_s       = '0;
    res_s       = '0;
    first_s     = (grp_cnt_q == '0);
    if (!first_s) begin
      gmax_s = grp_max_q;
    end else if (num_groups == '0) begin
      gmax_s = GRP_ONE;
    end else begin
      gmax_s = num_groups;
    end
    last_s = ({1'b0, grp_cnt_q} + {1'b0, GRP_ONE}) >= {1'b0, gmax_s};

    if (s3_v && en_s) begin
      grp_max_d = gmax_s;
      for (int f = 0; f < NUM_FILT; f++) begin
        if (first_s) begin
          base_s = '0;
        end else begin
          base_s = acc_q[f];
        end
        wide_s       = SAT_W'(base_s) + SAT_W'(tree_sum[f]);
        acc_s        = sat(wide_s, ACC_W);
        acc_d[f]     = acc_s[ACC_W-1:0];
        // Saturation stays sticky across the groups of one pixel.
        acc_sat_d[f] = (!first_s && acc_sat_q[f]) || (acc_s != wide_s);
        if (last_s) begin
          res_s         = sat(acc_s, bitsize);
          sat_flag_d[f] = acc_sat_d[f] || (res_s != acc_s);
`ifdef CONV_ACCUM_RELU_EN
          if (res_s < 64'sd0) begin
            res_s = '0;
          end else begin
            res_s = res_s;
          end
`endif
          out_data_d[f*bitsize +: bitsize] = res_s[bitsize-1:0];
        end else begin
          sat_flag_d[f] = sat_flag_q[f];
        end
      end
      case (state_q)
        IDLE, ACCUM: begin
          if (last_s) begin
            grp_cnt_d   = '0;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            grp_cnt_d = grp_cnt_q + GRP_ONE;
            state_d   = ACCUM;
          end
        end
        default: begin
          grp_cnt_d = '0;
          state_d   = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grp_cnt_q   <= '0;
      grp_max_q   <= '0;
      for (int f = 0; f < NUM_FILT; f++) acc_q[f] <= '0;
      acc_sat_q   <= '0;
      out_data_q  <= '0;
      sat_flag_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_cnt_q   <= grp_cnt_d;
      grp_max_q   <= grp_max_d;
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = en_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;
  assign busy      = (|tree_busy) || (grp_cnt_q != '0) || out_valid_q;

endmodule
